// File: rtl/wave_seq_pkg.sv
// Shared types for the wave sequencer: FSM state encoding and the packed table entry.
package wave_seq_pkg;

    localparam int ENTRY_W = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] duty;
        logic [15:0] cycles;
        logic [15:0] gap;
    } entry_t;

    function automatic entry_t make_entry(
        input logic [31:0] freq,
        input logic [15:0] duty,
        input logic [15:0] cycles,
        input logic [15:0] gap
    );
        entry_t e;
        e.freq   = freq;
        e.duty   = duty;
        e.cycles = cycles;
        e.gap    = gap;
        return e;
    endfunction

endpackage

// File: rtl/wave_seq_table.sv
// Append-only entry table with fill count, write-rejection pulse and a
// combinational read port at the active entry index.
module wave_seq_table
    import wave_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idle,
    input  logic             wr_en,
    input  entry_t           wr_entry,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output entry_t           rd_entry,
    output logic [IDX_W:0]   count,
    output logic             full,
    output logic             wr_err
);

    entry_t mem [DEPTH];

    logic clear_ok;
    logic wr_ok;
    logic reject;

    assign full     = (count == (IDX_W+1)'(DEPTH));
    assign clear_ok = clear && idle;
    // clear beats a simultaneous write; the dropped write is not an error.
    assign wr_ok    = wr_en && !clear && idle && !full;
    assign reject   = (clear && !idle) || (wr_en && !clear && (!idle || full));
    assign rd_entry = mem[rd_idx];

    // NOTE: the storage array has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[count[IDX_W-1:0]] <= wr_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= reject;
            if (clear_ok) begin
                count <= '0;
            end else if (wr_ok) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Burst sequencer: walks the entry table, programs the square-wave generator,
// runs each burst until the generator reports completion, then idles for the gap.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [31:0]      wr_freq,
    input  logic [15:0]      wr_duty,
    input  logic [15:0]      wr_cycles,
    input  logic [15:0]      wr_gap,
    input  logic             clear,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    output logic             full,
    output logic [IDX_W:0]   count,
    output logic             busy,
    output logic             done_pulse,
    output logic             wr_err,
    output logic [IDX_W-1:0] entry_idx,
    output logic [31:0]      gen_freq,
    output logic [15:0]      gen_duty,
    output logic [15:0]      gen_cycles,
    output logic             gen_run,
    input  logic             gen_ofs_kill
);

    state_t      state;
    entry_t      rd_entry;
    logic [15:0] gap_cnt;
    logic        first_run;

    wave_seq_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .idle     (state == IDLE),
        .wr_en    (wr_en),
        .wr_entry (make_entry(wr_freq, wr_duty, wr_cycles, wr_gap)),
        .clear    (clear),
        .rd_idx   (entry_idx),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full),
        .wr_err   (wr_err)
    );

    // Next-entry decision, shared by the burst-end and gap-end paths.
    logic             more;
    state_t           adv_state;
    logic [IDX_W-1:0] adv_idx;
    logic             adv_done;

    assign more = ({1'b0, entry_idx} + (IDX_W+1)'(1)) < count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        adv_state = LOAD;
        adv_idx   = entry_idx + 1'b1;
        adv_done  = 1'b0;
        if (!more) begin
            if (loop) begin
                adv_idx = '0;
            end else begin
                adv_state = IDLE;
                adv_idx   = entry_idx;
                adv_done  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            entry_idx  <= '0;
            gen_freq   <= '0;
            gen_duty   <= '0;
            gen_cycles <= '0;
            gen_run    <= 1'b0;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            gap_cnt    <= '0;
            first_run  <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                gen_run   <= 1'b0;
                first_run <= 1'b0;
                gap_cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && count != '0) begin
                            state     <= LOAD;
                            entry_idx <= '0;
                            busy      <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // gen_run was low throughout LOAD, so the generator starts from phase 0.
                        gen_freq   <= rd_entry.freq;
                        gen_duty   <= rd_entry.duty;
                        gen_cycles <= rd_entry.cycles;
                        gen_run    <= 1'b1;
                        first_run  <= 1'b1;
                        state      <= RUN;
                    end
                    RUN: begin
                        first_run <= 1'b0;
                        // gen_ofs_kill still reflects the previous burst during the first RUN clock.
                        if (!first_run && !gen_ofs_kill && gen_cycles != '0) begin
                            gen_run <= 1'b0;
                            if (rd_entry.gap != '0) begin
                                state   <= GAP;
                                gap_cnt <= rd_entry.gap;
                            end else begin
                                state      <= adv_state;
                                entry_idx  <= adv_idx;
                                done_pulse <= adv_done;
                                busy       <= !adv_done;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt <= 16'd1) begin
                            gap_cnt    <= '0;
                            state      <= adv_state;
                            entry_idx  <= adv_idx;
                            done_pulse <= adv_done;
                            busy       <= !adv_done;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
